// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle: redirect inputs, instruction-SRAM handshake and IF/ID delivery.
interface pc_fetch_if;
  logic [1:0]  pc_src;
  logic [31:0] branch_target;
  logic [31:0] epc;
  logic        id_stall;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  // master: the fetch unit itself
  modport master (
    input  pc_src, branch_target, epc, id_stall,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output inst_req, inst_addr,
    output if_valid, if_pc, if_inst, if_adel
  );

  // slave: decode/SRAM side
  modport slave (
    output pc_src, branch_target, epc, id_stall,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  inst_req, inst_addr,
    input  if_valid, if_pc, if_inst, if_adel
  );
endinterface

// File: rtl/pc_fetch.sv
// Fetch-address generator and instruction-fetch sequencer.
// Keeps the architectural fetch PC, buffers redirects while a fetch is in
// flight and hands one instruction (or a misaligned-fetch slot) to IF/ID.
module pc_fetch #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  pc_fetch_if.master  bus
);

  typedef enum logic [2:0] {
    ISSUE,
    WAIT_ADDR,
    WAIT_DATA,
    HOLD,
    ADEL
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        pend_valid;
  logic [1:0]  pend_src;
  logic [31:0] pend_addr;
  logic        cancel;
  logic [31:0] hold_inst;
  logic [31:0] hold_pc;
  logic        inst_req_q;
  logic [31:0] inst_addr_q;
  logic        req_nxt;

  logic [31:0] redir_addr;
  logic        redir_take;
  logic        redir_kill;
  logic        mrg_valid;
  logic [1:0]  mrg_src;
  logic [31:0] mrg_addr;

  logic        launch;
  logic        advance;
  logic        set_cancel;
  logic        clr_cancel;
  logic        capture;

  // Merge this cycle's redirect into the pending one by priority
  always_comb begin
    case (bus.pc_src)
      2'd2:    redir_addr = bus.epc;
      2'd3:    redir_addr = EXC_VECTOR;
      default: redir_addr = bus.branch_target;
    endcase
    redir_kill = bus.pc_src[1];
    // A branch seen while parked on a misaligned fetch is dropped
    redir_take = (bus.pc_src != 2'd0)
              && !((state == ADEL) && (bus.pc_src == 2'd1))
              && (!pend_valid || (bus.pc_src >= pend_src));
    mrg_valid = pend_valid;
    mrg_src   = pend_src;
    mrg_addr  = pend_addr;
    if (redir_take) begin
      mrg_valid = 1'b1;
      mrg_src   = bus.pc_src;
      mrg_addr  = redir_addr;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ISSUE;
    else     state <= state_nxt;
  end

  // Next-state and sequencing decisions
  always_comb begin
    state_nxt  = state;
    launch     = 1'b0;
    advance    = 1'b0;
    set_cancel = 1'b0;
    clr_cancel = 1'b0;
    capture    = 1'b0;
    case (state)
      ISSUE: begin
        if (pc[1:0] != 2'b00) begin
          state_nxt = ADEL;
        end else if (!inst_req_q) begin
          // First cycle out of reset: load the request register, stay here
          launch = 1'b1;
        end else begin
          // Address is already on the bus, so an eret/exception must kill it
          set_cancel = redir_kill;
          state_nxt  = bus.inst_addr_ok ? WAIT_DATA : WAIT_ADDR;
        end
      end
      WAIT_ADDR: begin
        set_cancel = redir_kill;
        if (bus.inst_addr_ok) state_nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (bus.inst_data_ok) begin
          if (cancel) begin
            clr_cancel = 1'b1;
            launch     = 1'b1;
            state_nxt  = ISSUE;
          end else if (!bus.id_stall) begin
            advance   = 1'b1;
            launch    = 1'b1;
            state_nxt = ISSUE;
          end else if (redir_kill) begin
            launch    = 1'b1;
            state_nxt = ISSUE;
          end else begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end else begin
          set_cancel = redir_kill;
        end
      end
      HOLD: begin
        if (!bus.id_stall) begin
          advance   = 1'b1;
          launch    = 1'b1;
          state_nxt = ISSUE;
        end else if (redir_kill) begin
          launch    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ADEL: begin
        if (mrg_valid && mrg_src[1]) begin
          launch    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = ISSUE;
    endcase
  end

  // Address for the next issue; the request register is loaded one cycle
  // ahead so inst_req is already high during ISSUE
  always_comb begin
    if (mrg_valid)    pc_nxt = mrg_addr;
    else if (advance) pc_nxt = pc + 32'd4;
    else              pc_nxt = pc;
    req_nxt = (state_nxt == WAIT_ADDR) || (launch && (pc_nxt[1:0] == 2'b00));
  end

  // PC, redirect buffer, cancel flag, hold buffer and registered request
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_src    <= 2'd0;
      pend_addr   <= '0;
      cancel      <= 1'b0;
      hold_inst   <= '0;
      hold_pc     <= '0;
      inst_req_q  <= 1'b0;
      inst_addr_q <= RESET_PC;
    end else begin
      if (launch) begin
        pc          <= pc_nxt;
        inst_addr_q <= pc_nxt;
        pend_valid  <= 1'b0;
      end else begin
        pend_valid <= mrg_valid;
        pend_src   <= mrg_src;
        pend_addr  <= mrg_addr;
      end
      if (clr_cancel)      cancel <= 1'b0;
      else if (set_cancel) cancel <= 1'b1;
      if (capture) begin
        hold_inst <= bus.inst_rdata;
        hold_pc   <= pc;
      end
      inst_req_q <= req_nxt;
    end
  end

  assign bus.inst_req  = inst_req_q;
  assign bus.inst_addr = inst_addr_q;

  // IF/ID delivery outputs
  always_comb begin
    bus.if_valid = 1'b0;
    bus.if_pc    = '0;
    bus.if_inst  = '0;
    bus.if_adel  = 1'b0;
    case (state)
      WAIT_DATA: begin
        if (bus.inst_data_ok && !cancel) begin
          bus.if_valid = 1'b1;
          bus.if_pc    = pc;
          bus.if_inst  = bus.inst_rdata;
        end
      end
      HOLD: begin
        bus.if_valid = 1'b1;
        bus.if_pc    = hold_pc;
        bus.if_inst  = hold_inst;
      end
      ADEL: begin
        bus.if_valid = 1'b1;
        bus.if_pc    = pc;
        bus.if_adel  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch.
module tb_pc_fetch;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_PC = 32'hBFC0_0380;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pc_fetch_if bus ();

  pc_fetch #(
    .RESET_PC   (RST_PC),
    .EXC_VECTOR (EXC_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic [31:0] addr);
    chk({tag, "_req"}, 32'(bus.inst_req), 32'd1);
    chk({tag, "_addr"}, bus.inst_addr, addr);
  endtask

  task automatic chk_if(input string tag, input logic v, input logic [31:0] p,
                        input logic [31:0] ins, input logic a);
    #1;
    chk({tag, "_valid"}, 32'(bus.if_valid), 32'(v));
    if (v) begin
      chk({tag, "_pc"}, bus.if_pc, p);
      chk({tag, "_inst"}, bus.if_inst, ins);
      chk({tag, "_adel"}, 32'(bus.if_adel), 32'(a));
    end
  endtask

  // Fetch at addr: aw cycles before addr_ok, dw idle cycles before data_ok
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data,
                       input int unsigned aw, input int unsigned dw);
    chk_req(tag, addr);
    for (int unsigned i = 0; i < aw; i++) begin
      tick();
      chk_req({tag, "_w"}, addr);
    end
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    for (int unsigned i = 0; i < dw; i++) begin
      chk_if({tag, "_gap"}, 1'b0, '0, '0, 1'b0);
      tick();
    end
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = data;
    chk_if({tag, "_dlv"}, 1'b1, addr, data, 1'b0);
    tick();
    bus.inst_data_ok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst                = 1'b1;
    bus.pc_src         = 2'd0;
    bus.branch_target  = '0;
    bus.epc            = '0;
    bus.id_stall       = 1'b0;
    bus.inst_addr_ok   = 1'b0;
    bus.inst_data_ok   = 1'b0;
    bus.inst_rdata     = '0;
    tick();
    tick();
    chk("rst_req", 32'(bus.inst_req), 32'd0);
    chk("rst_addr", bus.inst_addr, RST_PC);
    chk_if("rst_if", 1'b0, '0, '0, 1'b0);
    chk("rst_ifpc", bus.if_pc, 32'd0);
    chk("rst_ifinst", bus.if_inst, 32'd0);
    chk("rst_adel", 32'(bus.if_adel), 32'd0);

    // Sequential fetches
    rst = 1'b0;
    tick();
    fetch("seq0", 32'hBFC0_0000, 32'h1111_0000, 1, 0);
    fetch("seq1", 32'hBFC0_0004, 32'h1111_0004, 0, 1);
    fetch("seq2", 32'hBFC0_0008, 32'h1111_0008, 0, 0);

    // Branch during WAIT_DATA: delay slot delivered, then target
    chk_req("br", 32'hBFC0_000C);
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok  = 1'b0;
    bus.pc_src        = 2'd1;
    bus.branch_target = 32'h8000_1000;
    tick();
    bus.pc_src = 2'd0;
    chk("br_req_low", 32'(bus.inst_req), 32'd0);
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h2222_000C;
    chk_if("br_slot", 1'b1, 32'hBFC0_000C, 32'h2222_000C, 1'b0);
    tick();
    bus.inst_data_ok = 1'b0;
    fetch("br_tgt", 32'h8000_1000, 32'h3333_1000, 0, 0);

    // Exception during WAIT_ADDR: response dropped, vector fetched
    chk_req("exc", 32'h8000_1004);
    tick();
    bus.pc_src = 2'd3;
    tick();
    bus.pc_src = 2'd0;
    chk_req("exc_stable", 32'h8000_1004);
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hDEAD_0001;
    chk_if("exc_drop", 1'b0, '0, '0, 1'b0);
    tick();
    bus.inst_data_ok = 1'b0;
    fetch("exc_vec", EXC_PC, 32'h4444_0380, 0, 0);

    // Branch then exception in consecutive cycles
    chk_req("p13", 32'hBFC0_0384);
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok  = 1'b0;
    bus.pc_src        = 2'd1;
    bus.branch_target = 32'h8000_2000;
    tick();
    bus.pc_src = 2'd3;
    tick();
    bus.pc_src       = 2'd0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hDEAD_0002;
    chk_if("p13_drop", 1'b0, '0, '0, 1'b0);
    tick();
    bus.inst_data_ok = 1'b0;
    fetch("p13_vec", EXC_PC, 32'h5555_0380, 0, 0);

    // Exception then branch: branch loses
    chk_req("p31", 32'hBFC0_0384);
    tick();
    bus.pc_src = 2'd3;
    tick();
    bus.pc_src        = 2'd1;
    bus.branch_target = 32'h8000_3000;
    tick();
    bus.pc_src = 2'd0;
    chk_req("p31_stable", 32'hBFC0_0384);
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hDEAD_0003;
    chk_if("p31_drop", 1'b0, '0, '0, 1'b0);
    tick();
    bus.inst_data_ok = 1'b0;

    // id_stall held for three cycles on delivery
    chk_req("stl", EXC_PC);
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hA5A5_0005;
    bus.id_stall     = 1'b1;
    chk_if("stl_c0", 1'b1, EXC_PC, 32'hA5A5_0005, 1'b0);
    tick();
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'h0;
    for (int k = 0; k < 2; k++) begin
      chk_if("stl_hold", 1'b1, EXC_PC, 32'hA5A5_0005, 1'b0);
      chk("stl_noreq", 32'(bus.inst_req), 32'd0);
      tick();
    end
    bus.id_stall = 1'b0;
    chk_if("stl_rel", 1'b1, EXC_PC, 32'hA5A5_0005, 1'b0);
    tick();
    chk_req("stl_next", 32'hBFC0_0384);
    chk_if("stl_idle", 1'b0, '0, '0, 1'b0);

    // Branch to misaligned target: ADEL slot until exception
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok  = 1'b0;
    bus.pc_src        = 2'd1;
    bus.branch_target = 32'h8000_0002;
    tick();
    bus.pc_src       = 2'd0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h6666_0384;
    chk_if("adel_slot", 1'b1, 32'hBFC0_0384, 32'h6666_0384, 1'b0);
    tick();
    bus.inst_data_ok = 1'b0;
    chk("adel_noreq0", 32'(bus.inst_req), 32'd0);
    tick();
    chk("adel_noreq1", 32'(bus.inst_req), 32'd0);
    chk_if("adel_a", 1'b1, 32'h8000_0002, 32'h0, 1'b1);
    bus.pc_src        = 2'd1;
    bus.branch_target = 32'h8000_4000;
    tick();
    bus.pc_src = 2'd0;
    chk_if("adel_br_ign", 1'b1, 32'h8000_0002, 32'h0, 1'b1);
    chk("adel_noreq2", 32'(bus.inst_req), 32'd0);
    bus.pc_src = 2'd3;
    tick();
    bus.pc_src = 2'd0;
    chk_req("adel_exit", EXC_PC);

    // eret while held: slot dropped, epc fetched
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h7777_0380;
    bus.id_stall     = 1'b1;
    chk_if("eret_c0", 1'b1, EXC_PC, 32'h7777_0380, 1'b0);
    tick();
    bus.inst_data_ok = 1'b0;
    bus.pc_src       = 2'd2;
    bus.epc          = 32'h8000_5000;
    chk_if("eret_hold", 1'b1, EXC_PC, 32'h7777_0380, 1'b0);
    tick();
    bus.pc_src   = 2'd0;
    bus.id_stall = 1'b0;
    chk_if("eret_drop", 1'b0, '0, '0, 1'b0);
    chk_req("eret_epc", 32'h8000_5000);

    // PC wraps modulo 2^32
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok  = 1'b0;
    bus.pc_src        = 2'd1;
    bus.branch_target = 32'hFFFF_FFFC;
    tick();
    bus.pc_src       = 2'd0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h8888_5000;
    chk_if("wrap_slot", 1'b1, 32'h8000_5000, 32'h8888_5000, 1'b0);
    tick();
    bus.inst_data_ok = 1'b0;
    fetch("wrap_top", 32'hFFFF_FFFC, 32'h9999_FFFC, 0, 0);
    chk_req("wrap_zero", 32'h0000_0000);

    // Reset mid-fetch, then a stray data_ok is ignored
    bus.inst_addr_ok = 1'b1;
    tick();
    bus.inst_addr_ok = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_req", 32'(bus.inst_req), 32'd0);
    chk("mrst_addr", bus.inst_addr, RST_PC);
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hDEAD_0004;
    chk_if("mrst_stray0", 1'b0, '0, '0, 1'b0);
    tick();
    chk_req("mrst_first", RST_PC);
    chk_if("mrst_stray1", 1'b0, '0, '0, 1'b0);
    bus.inst_data_ok = 1'b0;
    fetch("mrst_f", RST_PC, 32'hAAAA_0000, 0, 0);
    chk_req("mrst_next", 32'hBFC0_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
